// File: rtl/snes_port_pkg.sv
// Shared types and defaults for the SNES/NES controller port sequencer.
package snes_port_pkg;

  localparam int   NBITS_DEF    = 16;
  localparam int   TIMEOUT_DEF  = 20000;
  localparam logic FILL_BIT_DEF = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Observation bundle: FSM state plus the synchronised pin levels and edges.
  typedef struct packed {
    state_t state;
    logic   latch_s;
    logic   clk_s;
    logic   latch_rise;
    logic   clk_rise;
    logic   clk_fall;
  } dbg_t;

  // Counter width able to hold TIMEOUT_CYCLES-1.
  function automatic int timeout_width(input int cycles);
    return (cycles < 3) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/snes_port_sequencer_sync_edge.sv
// Multi-flop synchroniser for one asynchronous console pin, with rise/fall
// detection against one further registered copy of the synchronised level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_level = r_chain[STAGES-1];
  assign o_rise  = r_chain[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/snes_port_sequencer.sv
// Latch/shift frame engine for one console controller port: synchronises the
// pad pins, holds the latest USB snapshot and drives 4021-style serial data.
module snes_port_sequencer
  import snes_port_pkg::*;
#(
  parameter int   NBITS          = NBITS_DEF,
  parameter int   SYNC_STAGES    = 2,
  parameter int   TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic FILL_BIT       = FILL_BIT_DEF,
  localparam int  CW             = $clog2(NBITS + 1)
) (
  input  logic             system_clock,
  input  logic             rst_n,
  input  logic             pad_latch,
  input  logic             pad_clk,
  output logic             pad_data,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [NBITS-1:0] upd_buttons,
  output logic             frame_strobe,
  output logic             frame_abort,
  output logic [CW-1:0]    bit_count,
  output dbg_t             o_dbg,
  output logic [NBITS-1:0] o_dbg_pending
);

  localparam int            TW       = timeout_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MAX  = '1;
  localparam logic [CW-1:0] BC_LAST  = CW'(NBITS - 1);

  logic w_latch_s, w_latch_rise, w_latch_fall;
  logic w_clk_s, w_clk_rise, w_clk_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .i_clk   (system_clock),
    .i_rst_n (rst_n),
    .i_async (pad_latch),
    .o_level (w_latch_s),
    .o_rise  (w_latch_rise),
    .o_fall  (w_latch_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .i_clk   (system_clock),
    .i_rst_n (rst_n),
    .i_async (pad_clk),
    .o_level (w_clk_s),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  state_t           r_state, w_state_n;
  logic [NBITS-1:0] r_pending, r_shreg, w_shreg_n;
  logic [CW-1:0]    r_bit_count, w_bc_n;
  logic [TW-1:0]    r_tmr, w_tmr_n;
  logic             r_pad_data, w_pad_n;
  logic             r_strobe, w_strobe_n;
  logic             r_abort, w_abort_n;
  logic             w_shift;

  // Snapshot handshake: a transfer happens on any edge where upd_valid and
  // upd_ready are both high; ready drops only while the console holds latch,
  // and an accepted snapshot simply replaces the pending one.
  assign upd_ready = ~w_latch_s;

  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // A latch rise always restarts the frame, pre-empting shifts and timeouts.
  always_comb begin
    w_state_n  = r_state;
    w_shift    = 1'b0;
    w_strobe_n = 1'b0;
    w_abort_n  = 1'b0;
    if (w_latch_rise) begin
      w_state_n = LATCH;
    end else begin
      case (r_state)
        IDLE:  w_state_n = IDLE;
        LATCH: begin
          if (w_latch_fall) begin
            w_state_n  = SHIFT;
            w_strobe_n = 1'b1;
          end
        end
        SHIFT: begin
          if (w_clk_rise) begin
            w_shift = 1'b1;
            if (r_bit_count == BC_LAST) w_state_n = DONE;
          end else if (r_tmr == TMR_LAST) begin
            w_state_n = IDLE;
            w_abort_n = 1'b1;
          end
        end
        DONE:    w_state_n = DONE;
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    w_shreg_n = r_shreg;
    if (w_state_n == LATCH) begin
      w_shreg_n = r_pending;
    end else if (w_shift) begin
      w_shreg_n = {FILL_BIT, r_shreg[NBITS-1:1]};
    end
  end

  // pad_data is decoded from next-state values so the pin comes straight
  // from a flop and never glitches.
  always_comb begin
    w_pad_n = FILL_BIT;
    if (w_state_n == LATCH || w_state_n == SHIFT) w_pad_n = w_shreg_n[0];
  end

  always_comb begin
    w_bc_n = r_bit_count;
    if (w_state_n == LATCH || w_state_n == IDLE) begin
      w_bc_n = '0;
    end else if (w_shift) begin
      w_bc_n = r_bit_count + 1'b1;
    end
  end

  always_comb begin
    w_tmr_n = r_tmr;
    if (w_state_n != SHIFT || r_state != SHIFT || w_clk_rise) begin
      w_tmr_n = '0;
    end else if (r_tmr != TMR_MAX) begin
      w_tmr_n = r_tmr + 1'b1;
    end
  end

  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '1;
      r_shreg     <= '1;
      r_bit_count <= '0;
      r_tmr       <= '0;
      r_pad_data  <= 1'b1;
      r_strobe    <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      if (upd_valid && upd_ready) r_pending <= upd_buttons;
      r_shreg     <= w_shreg_n;
      r_bit_count <= w_bc_n;
      r_tmr       <= w_tmr_n;
      r_pad_data  <= w_pad_n;
      r_strobe    <= w_strobe_n;
      r_abort     <= w_abort_n;
    end
  end

  assign pad_data      = r_pad_data;
  assign frame_strobe  = r_strobe;
  assign frame_abort   = r_abort;
  assign bit_count     = r_bit_count;
  assign o_dbg_pending = r_pending;

  always_comb begin
    o_dbg.state      = r_state;
    o_dbg.latch_s    = w_latch_s;
    o_dbg.clk_s      = w_clk_s;
    o_dbg.latch_rise = w_latch_rise;
    o_dbg.clk_rise   = w_clk_rise;
    o_dbg.clk_fall   = w_clk_fall;
  end

endmodule

// File: doc/snes_port_sequencer.md
Name: snes_port_sequencer

Overview:
Console-facing sequencer for one SNES/NES controller port. It synchronises the console's latch and clock pins into the system_clock domain and accepts button snapshots from the USB side through a valid/ready handshake. It runs the latch/shift frame state machine and drives the serial data pin with 4021-style timing. It sits between the USB report decoder and the port pins and replaces a free-running shift register with a controlled, abort-safe frame engine.

Parameters:
NBITS, 16, bits per frame (12 real buttons + 4 ID bits on SNES; 8 for NES)
SYNC_STAGES, 2, synchroniser flops per console input (minimum 2)
TIMEOUT_CYCLES, 20000, system_clock cycles without a pad_clk edge before a partial frame aborts (1 ms at 20 MHz)
FILL_BIT, 1, level driven after the last bit and when idle

Ports:
system_clock  in  1  20 MHz system clock
rst_n  in  1  asynchronous active-low reset
pad_latch  in  1  console latch, asynchronous
pad_clk  in  1  console data clock, asynchronous; idles low
pad_data  out  1  serial data to console
upd_valid  in  1  new snapshot offered
upd_ready  out  1  snapshot can be accepted
upd_buttons  in  NBITS  snapshot; bit 0 is shifted out first; active-low button levels
frame_strobe  out  1  one-cycle pulse on the synchronised latch falling edge
frame_abort  out  1  one-cycle pulse on timeout
bit_count  out  $clog2(NBITS+1)  bits shifted in the current frame

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; synchroniser flops=0; pending={NBITS{1}}; shreg={NBITS{1}}.
  - bit_count=0; pad_data=1; strobes=0; timeout counter=0.
- Sync: latch_s and clk_s are the last flops of each SYNC_STAGES chain. Rise/fall are detected against one further registered copy.
- Latency: pad_data changes SYNC_STAGES+1 cycles after a pad pin edge (150 ns at the defaults).
- Update handshake:
  - upd_ready = !latch_s.
  - On upd_valid && upd_ready, pending <= upd_buttons on that edge.
  - Snapshots are never blocked outside latch. A newer accepted snapshot overwrites an older one; there is no queue.
- pad_data = shreg[0] in LATCH and SHIFT, and FILL_BIT in IDLE and DONE. It is registered and glitch-free.
- States:
  - IDLE: on latch rise -> LATCH.
  - LATCH: shreg <= pending every cycle (transparent parallel load); bit_count=0. On latch fall -> SHIFT, frame_strobe=1 for that cycle.
  - SHIFT: on clk_s rise, shreg <= {FILL_BIT, shreg[NBITS-1:1]} and bit_count++. When bit_count reaches NBITS on that edge -> DONE.
  - DONE: further clk rises are ignored; bit_count holds NBITS; pad_data=FILL_BIT. On latch rise -> LATCH.
- Timeout:
  - The counter runs only in SHIFT and clears on every clk_s rise and on entry to SHIFT.
  - At TIMEOUT_CYCLES-1: -> IDLE, frame_abort=1 for one cycle, bit_count=0.
  - The counter saturates; it never wraps.
- Latch rise in any state (including mid-SHIFT) -> LATCH immediately; the partial frame is discarded and no abort pulse is issued.
- Simultaneous latch rise and clk rise in the same cycle: latch wins; no shift.
- Clk rise while in LATCH or IDLE: ignored.
- Reset asserted mid-frame: all outputs take reset values asynchronously; the frame is lost.

Decomposition:
- Package snes_port_pkg holds:
  - the state enum (IDLE, LATCH, SHIFT, DONE);
  - FILL_BIT and NBITS defaults;
  - the timeout width function.
- One sub-module, sync_edge, provides the SYNC_STAGES synchroniser plus rise/fall detector with reset to 0. It is instantiated twice, for latch and clk.

Test Plan:
- Reset then idle 100 cycles -> pad_data=1, upd_ready=1, bit_count=0, no strobes.
- Accept upd_buttons=16'hAAAA, latch 5 µs, 16 clk pulses of 5 µs -> pad_data sequence 0,1,0,1,... (bit 0 first). frame_strobe pulses once. bit_count ends at 16. A 17th clk gives pad_data=1.
- Offer 16'h5555 with upd_valid while latch is high -> upd_ready=0, no accept. The frame shifts the prior snapshot. After latch falls, the offer is accepted and the next frame shifts 1,0,1,0,...
- TIMEOUT_CYCLES=2000: latch, then 5 clks, then silence -> frame_abort one pulse 2000 cycles after the 5th synchronised edge. State becomes IDLE; pad_data=1.
- Latch rise after bit 7 of a frame -> immediate reload, bit_count=0, pad_data=new bit 0, no frame_abort.
- Assert rst_n=0 mid-SHIFT with pad_clk toggling -> pad_data=1 at once. After release, the state is IDLE and the pending snapshot reads back as 16'hFFFF.
